// File: rtl/mult_issue_ctrl.sv
// mult_issue_ctrl: issue stage for the 4-bit shift-add multiplier.
// Operand pairs are buffered in a DEPTH-entry FIFO and issued one at a time
// with a single-cycle start pulse. Products come back on a valid/ready port.
// Optional feature macro: MIC_TIMEOUT_EN adds a watchdog over WAIT_LO/WAIT_HI
// that aborts a hung operation and raises a sticky err_timeout.
module mult_issue_ctrl #(
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 32
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [3:0] in_mplier,
    input  logic [3:0] in_mcand,
    output logic       mul_start,
    output logic [3:0] mul_mplier,
    output logic [3:0] mul_mcand,
    input  logic       mul_ready,
    input  logic [7:0] mul_product,
    output logic       res_valid,
    input  logic       res_ready,
    output logic [7:0] res_data,
    output logic       busy,
    output logic       err_timeout
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    // Parameter sanity: pointer wrap relies on a power-of-2 depth.
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("mult_issue_ctrl: DEPTH must be a power of 2 and >= 2");
    end
    if (TIMEOUT < 1) begin : g_bad_timeout
        $error("mult_issue_ctrl: TIMEOUT must be >= 1");
    end

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ISSUE   = 2'd1,
        S_WAIT_LO = 2'd2,
        S_WAIT_HI = 2'd3
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;

    logic [7:0]    r_mem [DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;

    logic          r_mul_start;
    logic [3:0]    r_mul_mplier;
    logic [3:0]    r_mul_mcand;
    logic          r_res_valid;
    logic [7:0]    r_res_data;

    logic          w_push;
    logic          w_pop;
    logic          w_empty;
    logic          w_capture;
    logic          w_abort;
    logic          w_tmo_hit;

    // in_ready is a pure function of the registered count, so a pop in the
    // same cycle never frees a slot for a push into a full FIFO.
    assign in_ready = (r_count != FULL_CNT);
    assign w_empty  = (r_count == '0);
    assign w_push   = in_valid && in_ready;

`ifdef MIC_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

    logic [TW-1:0] r_tmo_cnt;
    logic          r_err_timeout;
    logic          w_tmo_frozen;

    // Waiting on a full output register is not the multiplier's fault.
    assign w_tmo_frozen = (r_state == S_WAIT_HI) && r_res_valid && !res_ready;
    assign w_tmo_hit    = (r_tmo_cnt == TMO_LAST) && !w_tmo_frozen;

    // Watchdog: cleared while issuing, counts wait cycles unless backpressured.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_tmo_cnt <= '0;
        end else if (r_state == S_ISSUE) begin
            r_tmo_cnt <= '0;
        end else if ((r_state == S_WAIT_LO || r_state == S_WAIT_HI) &&
                     !w_tmo_frozen && !w_tmo_hit) begin
            r_tmo_cnt <= r_tmo_cnt + 1'b1;
        end
    end

    // Sticky error flag, cleared only by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_err_timeout <= 1'b0;
        end else if (w_abort) begin
            r_err_timeout <= 1'b1;
        end
    end

    assign err_timeout = r_err_timeout;
`else
    assign w_tmo_hit   = 1'b0;
    assign err_timeout = 1'b0;
`endif

    // FIFO storage; contents need no reset since count gates every read.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {in_mplier, in_mcand};
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally mod DEPTH.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            unique case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next state plus pop/capture/abort strobes.
    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        w_capture   = 1'b0;
        w_abort     = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (!w_empty && mul_ready) begin
                    w_pop       = 1'b1;
                    w_state_nxt = S_ISSUE;
                end
            end
            S_ISSUE: begin
                w_state_nxt = S_WAIT_LO;
            end
            S_WAIT_LO: begin
                // The multiplier must first drop ready to acknowledge start.
                if (w_tmo_hit) begin
                    w_abort     = 1'b1;
                    w_state_nxt = S_IDLE;
                end else if (!mul_ready) begin
                    w_state_nxt = S_WAIT_HI;
                end
            end
            S_WAIT_HI: begin
                // A capture wins over an abort landing on the same cycle.
                if (mul_ready && (!r_res_valid || res_ready)) begin
                    w_capture   = 1'b1;
                    w_state_nxt = S_IDLE;
                end else if (w_tmo_hit) begin
                    w_abort     = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Multiplier drive: one-cycle start, operands held until the next pop.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_mul_start  <= 1'b0;
            r_mul_mplier <= '0;
            r_mul_mcand  <= '0;
        end else begin
            r_mul_start <= w_pop;
            if (w_pop) begin
                {r_mul_mplier, r_mul_mcand} <= r_mem[r_rd_ptr];
            end
        end
    end

    // Result register: capture takes priority over drain in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_res_valid <= 1'b0;
            r_res_data  <= '0;
        end else if (w_capture) begin
            r_res_valid <= 1'b1;
            r_res_data  <= mul_product;
        end else if (res_ready) begin
            r_res_valid <= 1'b0;
        end
    end

    assign mul_start  = r_mul_start;
    assign mul_mplier = r_mul_mplier;
    assign mul_mcand  = r_mul_mcand;
    assign res_valid  = r_res_valid;
    assign res_data   = r_res_data;
    assign busy       = (r_state != S_IDLE) || !w_empty;

endmodule

// File: tb/tb_mult_issue_ctrl.sv
// Bench for mult_issue_ctrl: behavioural multiplier model, queue-based
// reference of accepted operands and expected products, directed scenarios
// plus a randomized traffic phase.
module tb_mult_issue_ctrl;

    localparam int DEPTH = 4;
    localparam int TMO   = 32;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [3:0] in_mplier = '0;
    logic [3:0] in_mcand = '0;
    logic       mul_start;
    logic [3:0] mul_mplier;
    logic [3:0] mul_mcand;
    logic       mul_ready;
    logic [7:0] mul_product;
    logic       res_valid;
    logic       res_ready = 1'b1;
    logic [7:0] res_data;
    logic       busy;
    logic       err_timeout;

    mult_issue_ctrl #(.DEPTH(DEPTH), .TIMEOUT(TMO)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_mplier  (in_mplier),
        .in_mcand   (in_mcand),
        .mul_start  (mul_start),
        .mul_mplier (mul_mplier),
        .mul_mcand  (mul_mcand),
        .mul_ready  (mul_ready),
        .mul_product(mul_product),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_data   (res_data),
        .busy       (busy),
        .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;

    // Multiplier model: ready low for mdl_n cycles after start, exact product.
    logic       mdl_rdy  = 1'b1;
    int         mdl_cnt  = 0;
    int         mdl_n    = 8;
    logic [7:0] mdl_prod = '0;
    logic       hang     = 1'b0;

    assign mul_ready   = mdl_rdy && !hang;
    assign mul_product = mdl_prod;

    always @(posedge clk) begin
        if (mul_start) begin
            mdl_rdy  <= 1'b0;
            mdl_cnt  <= mdl_n;
            mdl_prod <= 8'(mul_mplier) * 8'(mul_mcand);
        end else if (mdl_cnt > 1) begin
            mdl_cnt <= mdl_cnt - 1;
        end else if (mdl_cnt == 1) begin
            mdl_cnt <= 0;
            mdl_rdy <= 1'b1;
        end
    end

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %0d exp %0d", tag, got, exp);
        end
    endtask

    // Reference: accepted operands in order; products owed in order.
    logic [7:0] op_q[$];
    logic [7:0] exp_q[$];
    int         n_start = 0;
    int         n_res   = 0;
    logic [7:0] last_res = '0;
    logic       prev_start = 1'b0;
    logic       prev_hold  = 1'b0;
    logic [7:0] prev_data  = '0;
    logic       prev_err   = 1'b0;

    always @(negedge clk) begin
        if (rst) begin
            op_q.delete();
            exp_q.delete();
            prev_start = 1'b0;
            prev_hold  = 1'b0;
            prev_err   = 1'b0;
        end else begin
            if (mul_start) begin
                chk("start_width", 32'(prev_start), 0);
                if (op_q.size() == 0) begin
                    chk("spurious_start", 1, 0);
                end else begin
                    logic [7:0] op;
                    op = op_q.pop_front();
                    chk("issue_mplier", 32'(mul_mplier), 32'(op[7:4]));
                    chk("issue_mcand", 32'(mul_mcand), 32'(op[3:0]));
                    chk("outstanding", 32'(exp_q.size()), 32'(exp_q.size() <= 1 ? exp_q.size() : 1));
                    exp_q.push_back(8'(op[7:4]) * 8'(op[3:0]));
                end
                n_start++;
            end
            if (in_valid && in_ready) op_q.push_back({in_mplier, in_mcand});
            if (prev_hold) begin
                chk("hold_valid", 32'(res_valid), 1);
                chk("hold_data", 32'(res_data), 32'(prev_data));
            end
            if (res_valid && res_ready) begin
                if (exp_q.size() == 0) chk("spurious_res", 1, 0);
                else chk("res_data", 32'(res_data), 32'(exp_q.pop_front()));
                last_res = res_data;
                n_res++;
            end
            if (err_timeout && !prev_err && exp_q.size() > 0) void'(exp_q.pop_back());
            prev_start = mul_start;
            prev_hold  = res_valid && !res_ready;
            prev_data  = res_data;
            prev_err   = err_timeout;
        end
    end

    task automatic send(input logic [3:0] a, input logic [3:0] b);
        int k = 0;
        in_valid  = 1'b1;
        in_mplier = a;
        in_mcand  = b;
        @(negedge clk);
        while (!in_ready && k < 200) begin
            @(negedge clk);
            k++;
        end
        if (!in_ready) chk("send_timeout", 0, 1);
        @(posedge clk); #1;
    endtask

    task automatic wait_idle(input string tag);
        int k = 0;
        @(negedge clk);
        while ((busy || res_valid || !mul_ready) && k < 500) begin
            @(negedge clk);
            k++;
        end
        chk(tag, 32'(busy || res_valid || !mul_ready), 0);
        @(posedge clk); #1;
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    int   base_s, base_r, sent, k;
    logic acc;

    initial begin
        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_res_valid", 32'(res_valid), 0);
        chk("rst_res_data", 32'(res_data), 0);
        chk("rst_mul_start", 32'(mul_start), 0);
        chk("rst_operands", 32'({mul_mplier, mul_mcand}), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_err", 32'(err_timeout), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_in_ready", 32'(in_ready), 1);
        @(posedge clk); #1;

        // 1: single op, latency and one-cycle result
        mdl_n = 8;
        send(4'd5, 4'd3);
        in_valid = 1'b0;
        @(negedge clk);
        chk("lat_t1_start", 32'(mul_start), 0);
        @(negedge clk);
        chk("lat_t2_start", 32'(mul_start), 1);
        chk("t1_ops", 32'({mul_mplier, mul_mcand}), 32'({4'd5, 4'd3}));
        @(negedge clk);
        chk("t1_start_drop", 32'(mul_start), 0);
        k = 0;
        while (!res_valid && k < 100) begin
            @(negedge clk);
            k++;
        end
        chk("t1_res_valid", 32'(res_valid), 1);
        chk("t1_res_data", 32'(res_data), 15);
        @(negedge clk);
        chk("t1_res_1cyc", 32'(res_valid), 0);
        wait_idle("t1_idle");

        // 2: back-to-back, in-order
        base_s = n_start; base_r = n_res;
        send(4'd15, 4'd15);
        send(4'd0, 4'd7);
        send(4'd9, 4'd1);
        send(4'd4, 4'd4);
        in_valid = 1'b0;
        wait_idle("t2_idle");
        chk("t2_starts", 32'(n_start - base_s), 4);
        chk("t2_results", 32'(n_res - base_r), 4);
        chk("t2_last", 32'(last_res), 16);

        // 3: fill FIFO while multiplier stalls
        base_s = n_start; base_r = n_res;
        hang = 1'b1;
        for (int i = 0; i < DEPTH; i++) send(4'(i + 2), 4'(i + 3));
        in_mplier = 4'd1;
        in_mcand  = 4'd1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("t3_full_in_ready", 32'(in_ready), 0);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        chk("t3_busy", 32'(busy), 1);
        hang = 1'b0;
        wait_idle("t3_idle");
        chk("t3_starts", 32'(n_start - base_s), DEPTH);
        chk("t3_results", 32'(n_res - base_r), DEPTH);

        // 4: output backpressure across two ops
        base_s = n_start; base_r = n_res;
        mdl_n = 3;
        res_ready = 1'b0;
        send(4'd2, 4'd3);
        send(4'd7, 4'd5);
        in_valid = 1'b0;
        cyc(40);
        chk("t4_starts", 32'(n_start - base_s), 2);
        chk("t4_valid", 32'(res_valid), 1);
        chk("t4_data", 32'(res_data), 6);
        chk("t4_busy", 32'(busy), 1);
        res_ready = 1'b1;
        wait_idle("t4_idle");
        chk("t4_results", 32'(n_res - base_r), 2);
        chk("t4_last", 32'(last_res), 35);

        // 5: reset during WAIT_HI with entries queued
        mdl_n = 20;
        send(4'd1, 4'd2);
        send(4'd3, 4'd4);
        send(4'd5, 4'd6);
        in_valid = 1'b0;
        cyc(4);
        chk("t5_busy_pre", 32'(busy), 1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("t5_res_valid", 32'(res_valid), 0);
        chk("t5_busy", 32'(busy), 0);
        chk("t5_in_ready", 32'(in_ready), 1);
        chk("t5_start", 32'(mul_start), 0);
        base_s = n_start;
        cyc(40);
        chk("t5_no_start", 32'(n_start - base_s), 0);
        wait_idle("t5_idle");

`ifdef MIC_TIMEOUT_EN
        // 6: multiplier never completes
        mdl_n = 4;
        send(4'd9, 4'd9);
        in_valid = 1'b0;
        k = 0;
        @(negedge clk);
        while (!mul_start && k < 20) begin
            @(negedge clk);
            k++;
        end
        chk("t6_start", 32'(mul_start), 1);
        hang = 1'b1;
        k = 0;
        while (!err_timeout && k < 200) begin
            @(negedge clk);
            k++;
        end
        chk("t6_tmo_lat", 32'(k), TMO + 1);
        hang = 1'b0;
        @(negedge clk);
        chk("t6_err", 32'(err_timeout), 1);
        chk("t6_idle", 32'(busy), 0);
        chk("t6_no_res", 32'(res_valid), 0);
        @(posedge clk); #1;
        wait_idle("t6_model_idle");
        base_r = n_res;
        send(4'd3, 4'd2);
        in_valid = 1'b0;
        wait_idle("t6_next_idle");
        chk("t6_next_cnt", 32'(n_res - base_r), 1);
        chk("t6_next_data", 32'(last_res), 6);
`endif

        // Randomized traffic with random backpressure and latency
        base_r = n_res;
        sent = 0;
        for (int j = 0; j < 3000 && (sent < 40 || in_valid); j++) begin
            @(negedge clk);
            acc = in_valid && in_ready;
            @(posedge clk); #1;
            if (acc) in_valid = 1'b0;
            if (!in_valid && sent < 40 && $urandom_range(0, 2) != 0) begin
                in_valid  = 1'b1;
                in_mplier = 4'($urandom_range(0, 15));
                in_mcand  = 4'($urandom_range(0, 15));
                sent++;
            end
            res_ready = ($urandom_range(0, 3) != 0);
            mdl_n     = $urandom_range(1, 6);
        end
        in_valid  = 1'b0;
        res_ready = 1'b1;
        wait_idle("rnd_idle");
        chk("rnd_results", 32'(n_res - base_r), 40);
        chk("ref_queues_empty", 32'(op_q.size() + exp_q.size()), 0);

`ifdef MIC_TIMEOUT_EN
        chk("err_sticky", 32'(err_timeout), 1);
`else
        chk("err_tied_low", 32'(err_timeout), 0);
`endif
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("final_rst_err", 32'(err_timeout), 0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
